// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//
// Shares the single 32:1 register-file read mux between NREQ requesters.
// A round-robin search picks one winner per cycle. The winner's register
// address is registered onto the mux select. The mux output is captured
// one edge later and returned with a one-cycle rvalid pulse to that same
// requester.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-high reset
//   req     in   [NREQ]     per-requester read request (level)
//   addr    in   [NREQ*AW]  packed addresses, requester i at [i*AW +: AW]
//   hold    in   stall: no new grant while high; in-flight reads drain
//   gnt     out  [NREQ]     registered one-hot grant pulse
//   sel     out  [AW]       registered mux select
//   mux_p   in   [DW]       mux output, combinational from sel
//   rvalid  out  [NREQ]     registered one-hot data-valid pulse
//   rdata   out  [DW]       captured read data, shared by all requesters
//   busy    out  |gnt | |rvalid
module regfile_read_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic               hold,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      sel,
  input  logic [DW-1:0]      mux_p,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               busy
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [PW-1:0]   win;
  logic [AW-1:0]   win_addr;
  logic [PW-1:0]   ptr_next;
  logic [PW:0]     sum;
  logic [PW-1:0]   idx;
  logic [AW-1:0]   addr_a [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = addr[i*AW +: AW];
    end
  end

  // The requester currently holding gnt is masked so that a requester
  // dropping req one cycle late is not granted twice in a row.
  assign elig = req & ~gnt & {NREQ{~hold}};

  // Priority search beginning at ptr and wrapping NREQ-1 -> 0. The index
  // is built with an explicit subtract so non-power-of-two NREQ wraps
  // correctly.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_addr = '0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = PW'(sum);
      if (!found && elig[idx]) begin
        found    = 1'b1;
        win      = idx;
        win_addr = addr_a[idx];
      end
    end
  end

  assign ptr_next = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;

  // Grant stage: sel and ptr only move when a grant is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt <= '0;
      sel <= '0;
      ptr <= '0;
    end else begin
      gnt <= '0;
      if (found) begin
        gnt[win] <= 1'b1;
        sel      <= win_addr;
        ptr      <= ptr_next;
      end
    end
  end

  // Capture stage: the mux output is sampled on the edge after the grant
  // and held until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= gnt;
      if (|gnt) begin
        rdata <= mux_p;
      end
    end
  end

  assign busy = (|gnt) | (|rvalid);

endmodule
